input_debounce_sync: RTL

//  Conditions a raw asynchronous input (switch/button/ext. pin) into a clean, synchronous level.

---
 rtl/input_debounce_sync_if.sv | 21 ++
 rtl/input_debounce_sync.sv | 134 +++++++++++++
 2 files changed

// File: rtl/input_debounce_sync_if.sv
// Signal bundle for input_debounce_sync: the raw input goes in, and the conditioned level,
// its complement, the busy status and the optional edge pulses come out.
`timescale 1ns/1ps
interface input_debounce_sync_if;
    logic i_raw;
    logic o_q;
    logic o_q_bar;
    logic o_busy;
    logic o_rise;
    logic o_fall;

    modport master (
        output i_raw,
        input  o_q, o_q_bar, o_busy, o_rise, o_fall
    );

    modport slave (
        input  i_raw,
        output o_q, o_q_bar, o_busy, o_rise, o_fall
    );
endinterface

// File: rtl/input_debounce_sync.sv
// Turns a raw asynchronous pin into a clean synchronous level using a synchroniser chain,
// then a four-state debounce FSM with a stability counter.
// The optional RISE/FALL pulses are built only when DEBOUNCE_EDGE_PULSE_EN is defined.
`timescale 1ns/1ps
module input_debounce_sync #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter int   CNT_W           = 16,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_clr_n,
    input_debounce_sync_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_STABLE_LO,
        ST_WAIT_HI,
        ST_STABLE_HI,
        ST_WAIT_LO
    } state_t;

    localparam state_t           ST_RESET = RESET_VAL ? ST_STABLE_HI : ST_STABLE_LO;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_q;
    logic                   r_busy;

    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_q_nxt;
    logic                   w_busy_nxt;
    logic                   w_s;

    // Only the first flop ever samples the raw pin; everything downstream sees w_s.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_raw};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            ST_STABLE_LO: begin
                if (w_s) begin
                    w_state_nxt = ST_WAIT_HI;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_WAIT_HI: begin
                if (!w_s) begin
                    w_state_nxt = ST_STABLE_LO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_STABLE_HI;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_STABLE_HI: begin
                if (!w_s) begin
                    w_state_nxt = ST_WAIT_LO;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_WAIT_LO: begin
                if (w_s) begin
                    w_state_nxt = ST_STABLE_HI;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_STABLE_LO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
    end

    // The level is high in STABLE_HI and while a drop is still only a candidate (WAIT_LO).
    assign w_q_nxt    = (w_state_nxt == ST_STABLE_HI) || (w_state_nxt == ST_WAIT_LO);
    assign w_busy_nxt = (w_state_nxt == ST_WAIT_HI)   || (w_state_nxt == ST_WAIT_LO);

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state <= ST_RESET;
            r_cnt   <= '0;
            r_q     <= RESET_VAL;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign bus.o_q     = r_q;
    assign bus.o_q_bar = ~r_q;
    assign bus.o_busy  = r_busy;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic r_rise;
    logic r_fall;

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_q_nxt & ~r_q;
            r_fall <= ~w_q_nxt & r_q;
        end
    end

    assign bus.o_rise = r_rise;
    assign bus.o_fall = r_fall;
`else
    assign bus.o_rise = 1'b0;
    assign bus.o_fall = 1'b0;
`endif

endmodule
